// File: rtl/gates7_checker.sv
// gates7_checker: on-chip self-test that walks the seven-gate unit through all four input vectors and scores its outputs
module gates7_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [6:0]       f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_vec,
    output logic [6:0]       fail_mask
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SW = ERR_W + 3;
    localparam logic [3:0] SC_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    state_t r_state, w_state;
    logic [1:0] r_vi, w_vi, w_vi_inc, r_fail_vec, w_fail_vec;
    logic [3:0] r_sc, w_sc;
    logic r_a, w_a, r_b, w_b, r_busy, w_busy, r_done, w_done, r_pass, w_pass, r_failed, w_failed;
    logic [ERR_W-1:0] r_err, w_err, w_err_sat;
    logic [6:0] r_fail_mask, w_fail_mask, w_exp, w_mism;
    logic [2:0] w_pop;
    logic [SW-1:0] w_sum;
    assign w_exp     = {~(r_a ^ r_b), r_a ^ r_b, ~(r_a | r_b), ~(r_a & r_b), ~r_a, r_a | r_b, r_a & r_b};
    assign w_mism    = f ^ w_exp;
    assign w_pop     = 3'($countones(w_mism));
    assign w_sum     = SW'(r_err) + SW'(w_pop);
    assign w_err_sat = (w_sum > SW'(ERR_MAX)) ? ERR_MAX : w_sum[ERR_W-1:0];
    assign w_vi_inc  = r_vi + 2'd1;
    // state and result registers; everything clears immediately on rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_vi        <= '0;
            r_sc        <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_failed    <= 1'b0;
            r_err       <= '0;
            r_fail_vec  <= '0;
            r_fail_mask <= '0;
        end else begin
            r_state     <= w_state;
            r_vi        <= w_vi;
            r_sc        <= w_sc;
            r_a         <= w_a;
            r_b         <= w_b;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_pass      <= w_pass;
            r_failed    <= w_failed;
            r_err       <= w_err;
            r_fail_vec  <= w_fail_vec;
            r_fail_mask <= w_fail_mask;
        end
    end
    // next-state: hold a vector for the settle time, then score it and advance
    always_comb begin
        w_state     = r_state;
        w_vi        = r_vi;
        w_sc        = r_sc;
        w_a         = r_a;
        w_b         = r_b;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_pass      = r_pass;
        w_failed    = r_failed;
        w_err       = r_err;
        w_fail_vec  = r_fail_vec;
        w_fail_mask = r_fail_mask;
        case (r_state)
            IDLE: if (start) begin
                w_state     = RUN;
                w_vi        = '0;
                w_sc        = SC_LOAD;
                w_a         = 1'b0;
                w_b         = 1'b0;
                w_busy      = 1'b1;
                w_pass      = 1'b0;
                w_failed    = 1'b0;
                w_err       = '0;
                w_fail_vec  = '0;
                w_fail_mask = '0;
            end
            RUN: if (r_sc != 4'd0) begin
                w_sc = r_sc - 4'd1;
            end else begin
                w_err = w_err_sat;
                if (w_mism != 7'd0 && !r_failed) begin
                    w_failed    = 1'b1;
                    w_fail_vec  = r_vi;
                    w_fail_mask = w_mism;
                end
                if (r_vi != 2'd3) begin
                    w_vi = w_vi_inc;
                    w_a  = w_vi_inc[0];
                    w_b  = w_vi_inc[1];
                    w_sc = SC_LOAD;
                end else begin
                    w_state = DONE;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = (w_err_sat == '0);
                end
            end
            DONE: w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end
    assign a         = r_a;
    assign b         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail_vec;
    assign fail_mask = r_fail_mask;
endmodule

// File: tb/tb_gates7_checker.sv
// tb_gates7_checker: drives two checker instances with a modelled gate unit carrying injected faults
module tb_gates7_checker;
    logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
    logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
    logic [6:0] f0, f1, fm0, fm1;
    logic [4:0] err0;
    logic [1:0] err1, fv0, fv1;
    logic [3:0][6:0] inj0 = '0, inj1 = '0;
    int tests = 0, fails = 0, cur = 0;
    logic ca, cb, cbusy, cdone, cpass;
    int cerr, cfv;
    logic [6:0] cfm;

    always #5 clk = ~clk;

    gates7_checker #(.SETTLE_CYCLES(1), .ERR_W(5)) u0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .f(f0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .fail_vec(fv0), .fail_mask(fm0));
    gates7_checker #(.SETTLE_CYCLES(3), .ERR_W(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .f(f1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_vec(fv1), .fail_mask(fm1));

    // healthy gate unit from the truth tables as arithmetic
    function automatic logic [6:0] good(input logic x, input logic y);
        int ia = int'(x), ib = int'(y);
        good[0] = (ia * ib) == 1;
        good[1] = (ia + ib) > 0;
        good[2] = (1 - ia) == 1;
        good[3] = (1 - ia * ib) == 1;
        good[4] = (ia + ib) == 0;
        good[5] = (ia + ib) == 1;
        good[6] = ia == ib;
    endfunction

    always_comb f0 = good(a0, b0) ^ inj0[{b0, a0}];
    always_comb f1 = good(a1, b1) ^ inj1[{b1, a1}];
    always_comb begin
        ca    = cur != 0 ? a1 : a0;
        cb    = cur != 0 ? b1 : b0;
        cbusy = cur != 0 ? busy1 : busy0;
        cdone = cur != 0 ? done1 : done0;
        cpass = cur != 0 ? pass1 : pass0;
        cerr  = cur != 0 ? int'(err1) : int'(err0);
        cfv   = cur != 0 ? int'(fv1) : int'(fv0);
        cfm   = cur != 0 ? fm1 : fm0;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (cur != 0) start1 = v;
        else start0 = v;
    endtask

    // expected results from the fault masks: total bit errors, first faulty vector
    task automatic model(input logic [3:0][6:0] inj, input int emax, output int err, output int vec,
                         output logic [6:0] mask, output bit ok);
        int sum = 0;
        vec = 0;
        mask = '0;
        for (int v = 3; v >= 0; v--) begin
            sum += $countones(inj[v]);
            if (inj[v] != 0) begin
                vec = v;
                mask = inj[v];
            end
        end
        err = sum > emax ? emax : sum;
        ok = sum == 0;
    endtask

    task automatic run(input string tag, input int sel, input int rs, input int e_err, input int e_vec,
                       input logic [6:0] e_mask, input bit e_pass);
        int s = sel != 0 ? 3 : 1;
        bit found = 0;
        cur = sel;
        @(negedge clk) set_start(1'b1);
        @(negedge clk) set_start(1'b0);
        for (int j = 0; j < 200 && !found; j++) begin
            if (j > 0) @(negedge clk);
            if (cdone) begin
                found = 1;
                chk({tag, "/done_time"}, j, 4 * s);
            end else begin
                set_start(rs > 0 && j == rs);
                if (j < 4 * s) chk({tag, "/ab"}, int'({cb, ca}), j / s);
                if (j < 4 * s) chk({tag, "/busy"}, int'(cbusy), 1);
            end
        end
        if (!found) chk({tag, "/done_timeout"}, 0, 1);
        chk({tag, "/ab_end"}, int'({cb, ca, cbusy}), 0);
        chk({tag, "/err"}, cerr, e_err);
        chk({tag, "/pass"}, int'(cpass), int'(e_pass));
        chk({tag, "/fail_vec"}, cfv, e_vec);
        chk({tag, "/fail_mask"}, int'(cfm), int'(e_mask));
        set_start(1'b1);
        @(negedge clk) set_start(1'b0);
        chk({tag, "/done_pulse"}, int'({cdone, cbusy}), 0);
        @(negedge clk);
        chk({tag, "/no_restart"}, int'(cbusy), 0);
        chk({tag, "/hold"}, cerr, e_err);
    endtask

    typedef struct {
        int sel;
        logic [3:0][6:0] inj;
        int rs;
        int e_err;
        int e_vec;
        logic [6:0] e_mask;
        bit e_pass;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int e_err, e_vec;
        logic [6:0] e_mask;
        bit e_pass, seen;
        tbl[0] = '{0, {7'h00, 7'h00, 7'h00, 7'h00}, 0, 0, 0, 7'h00, 1'b1};
        tbl[1] = '{0, {7'h00, 7'h20, 7'h20, 7'h00}, 0, 2, 1, 7'h20, 1'b0};
        tbl[2] = '{0, {7'h04, 7'h04, 7'h04, 7'h04}, 0, 4, 0, 7'h04, 1'b0};
        tbl[3] = '{1, {7'h00, 7'h00, 7'h00, 7'h00}, 5, 0, 0, 7'h00, 1'b1};
        tbl[4] = '{1, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 0, 3, 0, 7'h7F, 1'b0};
        tbl[5] = '{0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 2, 28, 0, 7'h7F, 1'b0};
        tbl[6] = '{1, {7'h40, 7'h00, 7'h00, 7'h00}, 0, 1, 3, 7'h40, 1'b0};
        @(negedge clk);
        chk("reset/u0", int'({a0, b0, busy0, done0, pass0, err0, fv0, fm0}), 0);
        chk("reset/u1", int'({a1, b1, busy1, done1, pass1, err1, fv1, fm1}), 0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].sel != 0) inj1 = tbl[i].inj;
            else inj0 = tbl[i].inj;
            run($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].rs, tbl[i].e_err, tbl[i].e_vec, tbl[i].e_mask, tbl[i].e_pass);
        end
        cur = 0;
        inj0 = {7'h00, 7'h00, 7'h00, 7'h01};
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst/pre_vec2", int'({b0, a0, err0}), int'({2'b10, 5'd1}));
        #2 rst = 1'b1;
        #1 chk("rst/async", int'({a0, b0, busy0, done0, pass0, err0, fv0, fm0}), 0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int j = 0; j < 10; j++) @(negedge clk) seen |= done0 | busy0;
        chk("rst/no_done", int'(seen), 0);
        inj0 = '0;
        run("rst/rerun", 0, 0, 0, 0, 7'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            logic [3:0][6:0] r;
            int sel = int'($urandom_range(0, 1));
            for (int v = 0; v < 4; v++) r[v] = $urandom_range(0, 1) != 0 ? 7'($urandom) : 7'h00;
            model(r, sel != 0 ? 3 : 31, e_err, e_vec, e_mask, e_pass);
            if (sel != 0) inj1 = r;
            else inj0 = r;
            run($sformatf("rnd%0d", i), sel, int'($urandom_range(0, 6)), e_err, e_vec, e_mask, e_pass);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
